multicycle_sequencer: RTL

- Multi-cycle control sequencer for the 16-bit RISC core. It steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the datapath enables, ALU_OP and PC source.
- It handshakes with a variable-latency memory through MEM_REQ/MEM_ACK.
- It sits between the instruction register/ALU flags and the datapath, and replaces single-cycle use of the combinational control decode.

---
 rtl/multicycle_sequencer_if.sv | 31 +++
 rtl/multicycle_sequencer.sv | 78 +++++++
 2 files changed

// File: rtl/multicycle_sequencer_if.sv
// multicycle_sequencer_if: control/handshake bundle between the sequencer and the datapath/memory side.
interface multicycle_sequencer_if #(parameter int CNT_W = 16);
    logic             start;
    logic [3:0]       opcode;
    logic             zero;
    logic             mem_ack;
    logic             mem_req;
    logic             mem_we;
    logic             ir_en;
    logic             pc_en;
    logic [1:0]       pc_src;
    logic [1:0]       alu_op;
    logic             alu_src;
    logic             reg_we;
    logic             wb_sel;
    logic             busy;
    logic             halted;
    logic             err;
    logic [2:0]       state;
    logic [CNT_W-1:0] instr_cnt;
    modport master (
        output start, opcode, zero, mem_ack,
        input  mem_req, mem_we, ir_en, pc_en, pc_src, alu_op, alu_src, reg_we, wb_sel,
               busy, halted, err, state, instr_cnt
    );
    modport slave (
        input  start, opcode, zero, mem_ack,
        output mem_req, mem_we, ir_en, pc_en, pc_src, alu_op, alu_src, reg_we, wb_sel,
               busy, halted, err, state, instr_cnt
    );
endinterface

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: FETCH/DECODE/EXEC/MEM/WB control FSM for the 16-bit RISC core.
// Define ILLEGAL_TRAP_EN to send opcodes 13-15 to FAULT instead of executing them as NOP.
module multicycle_sequencer #(
    parameter int CNT_W        = 16,
    parameter int MEM_WAIT_MAX = 15
) (
    input logic clk,
    input logic rst_n,
    multicycle_sequencer_if.slave bus
);
    localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
                           S_MEM  = 3'd4, S_WB    = 3'd5, S_HALT   = 3'd6, S_FAULT = 3'd7;
    localparam logic [3:0] OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3, OP_ADDI = 4'd4,
                           OP_LW  = 4'd5, OP_SW  = 4'd6, OP_BEQ = 4'd7, OP_BNE = 4'd8,
                           OP_JMP = 4'd9, OP_ANDI = 4'd10, OP_HALT = 4'd12;
    localparam int WW = MEM_WAIT_MAX < 2 ? 1 : $clog2(MEM_WAIT_MAX + 1);
    localparam logic [WW-1:0] W_LAST = WW'(MEM_WAIT_MAX - 1);
    logic [2:0]       state, nxt;
    logic [3:0]       op_q;
    logic [WW-1:0]    wcnt;
    logic [CNT_W-1:0] cnt;
    logic             in_fetch, in_exec, in_mem, in_wb, alu_act, timeout, retire;
    assign in_fetch = state == S_FETCH;
    assign in_exec  = state == S_EXEC;
    assign in_mem   = state == S_MEM;
    assign in_wb    = state == S_WB;
    assign alu_act  = in_exec | in_mem;
    // wcnt holds the number of unacknowledged cycles already spent on this request
    assign timeout  = (MEM_WAIT_MAX != 0) && !bus.mem_ack && wcnt == W_LAST;
    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:   nxt = bus.start ? S_FETCH : S_IDLE;
            S_FETCH:  nxt = bus.mem_ack ? S_DECODE : timeout ? S_FAULT : S_FETCH;
`ifdef ILLEGAL_TRAP_EN
            S_DECODE: nxt = bus.opcode == OP_HALT ? S_HALT : bus.opcode > OP_HALT ? S_FAULT : S_EXEC;
`else
            S_DECODE: nxt = bus.opcode == OP_HALT ? S_HALT : S_EXEC;
`endif
            S_EXEC:   nxt = (op_q <= OP_ADDI || op_q == OP_ANDI) ? S_WB :
                            (op_q == OP_LW || op_q == OP_SW) ? S_MEM : S_FETCH;
            S_MEM:    nxt = bus.mem_ack ? (op_q == OP_LW ? S_WB : S_FETCH) : timeout ? S_FAULT : S_MEM;
            S_WB:     nxt = S_FETCH;
            default:  nxt = state;
        endcase
    end
    assign retire = in_wb | (in_mem & bus.mem_ack & op_q == OP_SW) | (in_exec & nxt == S_FETCH);
    assign bus.mem_req   = in_fetch | in_mem;
    assign bus.mem_we    = in_mem & op_q == OP_SW;
    assign bus.ir_en     = in_fetch & bus.mem_ack;
    assign bus.pc_en     = (in_fetch & bus.mem_ack) |
                           (in_exec & ((op_q == OP_BEQ & bus.zero) | (op_q == OP_BNE & ~bus.zero) | op_q == OP_JMP));
    assign bus.pc_src    = !in_exec ? 2'b00 : (op_q == OP_BEQ || op_q == OP_BNE) ? 2'b01 :
                           op_q == OP_JMP ? 2'b10 : 2'b00;
    assign bus.alu_op    = !alu_act ? 2'b00 : (op_q == OP_SUB || op_q == OP_BEQ || op_q == OP_BNE) ? 2'b01 :
                           (op_q == OP_AND || op_q == OP_ANDI) ? 2'b10 : op_q == OP_OR ? 2'b11 : 2'b00;
    assign bus.alu_src   = alu_act & (op_q == OP_ADDI || op_q == OP_LW || op_q == OP_SW || op_q == OP_ANDI);
    assign bus.reg_we    = in_wb;
    assign bus.wb_sel    = in_wb & op_q == OP_LW;
    assign bus.busy      = state != S_IDLE && state < S_HALT;
    assign bus.halted    = state == S_HALT;
    assign bus.err       = state == S_FAULT;
    assign bus.state     = state;
    assign bus.instr_cnt = cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            op_q  <= '0;
            wcnt  <= '0;
            cnt   <= '0;
        end else begin
            state <= nxt;
            if (state == S_DECODE) op_q <= bus.opcode;
            wcnt <= (bus.mem_req && !bus.mem_ack) ? wcnt + 1'b1 : '0;
            if (retire) cnt <= cnt + 1'b1;
        end
    end
endmodule
